// File: rtl/common_types_pkg.sv
// Shared types and constants for the CPU/RAM interface blocks.
package common_types_pkg;

  localparam int unsigned RAM_LATENCY_DEFAULT = 2;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned DTAG_W  = WADDR_W + 1 + BE_W + WORD_W;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} ram_ctrl_state_t;

  // Full data-side request; doubles as the D hit-buffer tag.
  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic               ren;
    logic [BE_W-1:0]    wen;
    logic [WORD_W-1:0]  wdata;
  } dreq_t;

endpackage

// File: rtl/ram_controller_hit_buffer.sv
// Single-entry result buffer: load, tag-matched invalidate, combinational match.
module ram_hit_buffer
  import common_types_pkg::*;
#(
  parameter int unsigned TAG_W = WADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [WORD_W-1:0] data_in,
  input  logic              invalidate,
  input  logic [TAG_W-1:0]  inval_tag,
  input  logic [TAG_W-1:0]  cmp_tag,
  output logic              match_c,
  output logic [WORD_W-1:0] data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  // Load takes precedence; invalidate only drops an entry holding inval_tag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= tag_in;
      data  <= data_in;
    end else if (invalidate && (tag == inval_tag)) begin
      valid <= 1'b0;
    end
  end

  assign match_c = valid && (tag == cmp_tag);

endmodule

// File: rtl/ram_controller.sv
// Serialises CPU fetch and data requests onto one fixed-latency memory port,
// with per-port hit buffers so a stalled CPU sees a stable result.
module ram_controller
  import common_types_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = RAM_LATENCY_DEFAULT
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                iren,
  input  logic [WORD_W-1:0]   iaddr,
  output logic [WORD_W-1:0]   iload,
  output logic                iwait,
  input  logic                dren,
  input  logic [BE_W-1:0]     dwen,
  input  logic [WORD_W-1:0]   daddr,
  input  logic [WORD_W-1:0]   dstore,
  output logic [WORD_W-1:0]   dload,
  output logic                dwait,
  output logic                mem_ren,
  output logic [BE_W-1:0]     mem_wen,
  output logic [WADDR_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

  ram_ctrl_state_t  state;
  logic [CNT_W-1:0] cnt;

  dreq_t dcur;
  dreq_t dlat;
  logic  dreq, imatch, dmatch;
  logic  last_c, iload_en, dload_en, istore_inval;
  logic  unused_addr_lsbs;

  assign dcur = '{addr: daddr[31:2], ren: dren, wen: dwen, wdata: dstore};
  // The registered memory port is the latched request for the whole access.
  assign dlat = '{addr: mem_addr, ren: mem_ren, wen: mem_wen, wdata: mem_wdata};
  assign dreq = dren | (|dwen);
  assign unused_addr_lsbs = ^{iaddr[1:0], daddr[1:0]};

  assign last_c       = (state != IDLE) && (cnt == CNT_W'(MEM_LATENCY - 1));
  assign iload_en     = last_c && (state == IBUSY);
  assign dload_en     = last_c && (state == DBUSY);
  assign istore_inval = dload_en && (|mem_wen);

  assign iwait = iren & ~imatch;
  assign dwait = dreq & ~dmatch;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dreq && !dmatch) begin
            state     <= DBUSY;
            mem_ren   <= dren;
            mem_wen   <= dwen;
            mem_addr  <= daddr[31:2];
            mem_wdata <= dstore;
          end else if (iren && !imatch) begin
            state     <= IBUSY;
            mem_ren   <= 1'b1;
            mem_wen   <= '0;
            mem_addr  <= iaddr[31:2];
            mem_wdata <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (last_c) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A completed store drops any fetched copy of the same word.
  ram_hit_buffer #(.TAG_W(WADDR_W)) u_ibuf (
    .clk        (clk),
    .nrst       (nrst),
    .load       (iload_en),
    .tag_in     (mem_addr),
    .data_in    (mem_rdata),
    .invalidate (istore_inval),
    .inval_tag  (mem_addr),
    .cmp_tag    (iaddr[31:2]),
    .match_c    (imatch),
    .data       (iload)
  );

  ram_hit_buffer #(.TAG_W(DTAG_W)) u_dbuf (
    .clk        (clk),
    .nrst       (nrst),
    .load       (dload_en),
    .tag_in     (dlat),
    .data_in    (mem_rdata),
    .invalidate (1'b0),
    .inval_tag  ('0),
    .cmp_tag    (dcur),
    .match_c    (dmatch),
    .data       (dload)
  );

endmodule
